// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO word serializer.
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SEND,
        GUARD
    } ser_state_e;

    localparam int unsigned BYTE_W       = 8;
    // Cycles spent after a word so the FIFO's registered empty flag catches up with the pop.
    localparam int unsigned GUARD_CYCLES = 2;

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO-side and byte-stream-side signals of the word serializer.
interface fifo_word_serializer_if
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic              empty_i;
    logic [WIDTH-1:0]  data_i;
    logic              pop_o;
    logic [BYTE_W-1:0] byte_o;
    logic              valid_o;
    logic              ready_i;
    logic              busy_o;
    logic [15:0]       words_o;

    // Serializer side.
    modport master (
        input  empty_i, data_i, ready_i,
        output pop_o, byte_o, valid_o, busy_o, words_o
    );

    // FIFO / downstream side.
    modport slave (
        output empty_i, data_i, ready_i,
        input  pop_o, byte_o, valid_o, busy_o, words_o
    );

endinterface

// File: rtl/fifo_word_serializer.sv
// Pops one word from the FIFO and streams it out LSB byte first over valid/ready.
// Optional feature: define SER_CHECKSUM_EN to append an XOR checksum byte to every word.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    fifo_word_serializer_if.master  bus
);

    localparam int unsigned BYTES  = WIDTH / BYTE_W;
    localparam int unsigned IDX_W  = $clog2(BYTES + 1);
    localparam int unsigned GCNT_W = $clog2(GUARD_CYCLES);
`ifdef SER_CHECKSUM_EN
    localparam int unsigned LAST_IDX = BYTES;
`else
    localparam int unsigned LAST_IDX = BYTES - 1;
`endif

    ser_state_e         state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GCNT_W-1:0]  gcnt_q, gcnt_d;
    logic [15:0]        words_q, words_d;
    logic [BYTE_W-1:0]  cur_byte;
    logic               pop;
    logic               valid;
    logic [BYTE_W-1:0]  out_byte;
`ifdef SER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

    // Byte presented in SEND: data bytes, then the checksum slot when enabled.
`ifdef SER_CHECKSUM_EN
    assign cur_byte = (idx_q == IDX_W'(BYTES)) ? csum_q : shreg_q[BYTE_W-1:0];
`else
    assign cur_byte = shreg_q[BYTE_W-1:0];
`endif

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        gcnt_d   = gcnt_q;
        words_d  = words_q;
`ifdef SER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        pop      = 1'b0;
        valid    = 1'b0;
        out_byte = '0;

        unique case (state_q)
            IDLE: begin
                if (!bus.empty_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                pop     = 1'b1;
                shreg_d = bus.data_i;
                idx_d   = '0;
`ifdef SER_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = SEND;
            end
            SEND: begin
                valid    = 1'b1;
                out_byte = cur_byte;
                if (bus.ready_i) begin
                    shreg_d = shreg_q >> BYTE_W;
                    idx_d   = idx_q + 1'b1;
`ifdef SER_CHECKSUM_EN
                    csum_d  = csum_q ^ cur_byte;
`endif
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        words_d = words_q + 16'd1;
                        gcnt_d  = '0;
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                if (gcnt_q == GCNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers; reset drops any partially sent word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            gcnt_q  <= '0;
            words_q <= '0;
`ifdef SER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            words_q <= words_d;
`ifdef SER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.pop_o   = pop;
    assign bus.valid_o = valid;
    assign bus.byte_o  = out_byte;
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.words_o = words_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer; honours SER_CHECKSUM_EN when defined.
module tb_fifo_word_serializer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BYTES = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   pop_cnt = 0;
    int   dbl_pop = 0;
    logic prev_pop = 1'b0;

    always #5 clk = ~clk;

    fifo_word_serializer_if #(.WIDTH(WIDTH)) bus ();

    fifo_word_serializer #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running cycle count for pop spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Count pop pulses and flag any back-to-back pair.
    always @(negedge clk) begin
        if (bus.pop_o) pop_cnt++;
        if (bus.pop_o && prev_pop) dbl_pop++;
        prev_pop = bus.pop_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    // Wait (bounded) until pop_o is seen high; a timeout fails the check.
    task automatic wait_pop(input string tag);
        int n = 0;
        while (!bus.pop_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_pop"}, 32'(bus.pop_o), 32'd1);
    endtask

    // One full word with ready high; empty rises one cycle after the pop (flag lag).
    task automatic run_word(input string tag, input logic [31:0] w);
        bus.data_i  = w;
        bus.empty_i = 1'b0;
        bus.ready_i = 1'b1;
        wait_pop(tag);
        tick();
        bus.empty_i = 1'b1;
        for (int b = 0; b < BYTES; b++) begin
            if (b > 0) tick();
            chk({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
            chk({tag, "_byte"}, 32'(bus.byte_o), 32'(w[8*b +: 8]));
        end
`ifdef SER_CHECKSUM_EN
        tick();
        chk({tag, "_csum_valid"}, 32'(bus.valid_o), 32'd1);
        chk({tag, "_csum"}, 32'(bus.byte_o), 32'(xsum(w)));
`endif
        tick();
        chk({tag, "_guard_valid"}, 32'(bus.valid_o), 32'd0);
        chk({tag, "_guard_busy"}, 32'(bus.busy_o), 32'd1);
        tick();
        tick();
        chk({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int p0;
        int last_cyc;
        int sep;
        logic seen_pop, seen_busy, seen_valid;
        logic [31:0] bw [3];

        bw[0] = 32'h44332211;
        bw[1] = 32'h88776655;
        bw[2] = 32'hCCBBAA99;

        // Reset values
        bus.empty_i = 1'b1;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;
        tick();
        tick();
        chk("rst_pop",   32'(bus.pop_o),   32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_byte",  32'(bus.byte_o),  32'h00);
        chk("rst_busy",  32'(bus.busy_o),  32'd0);
        chk("rst_words", 32'(bus.words_o), 32'd0);
        rst = 1'b1;

        // Empty FIFO for 20 cycles: nothing happens
        seen_pop = 1'b0; seen_busy = 1'b0; seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_pop   |= bus.pop_o;
            seen_busy  |= bus.busy_o;
            seen_valid |= bus.valid_o;
        end
        chk("empty_pop",   32'(seen_pop),   32'd0);
        chk("empty_busy",  32'(seen_busy),  32'd0);
        chk("empty_valid", 32'(seen_valid), 32'd0);

        // Single word
        p0 = pop_cnt;
        run_word("single", 32'hDDCCBBAA);
        chk("single_pops",  32'(pop_cnt - p0), 32'd1);
        chk("single_words", 32'(bus.words_o), 32'd1);

        // Backpressure on byte BB for 5 cycles
        bus.data_i  = 32'hDDCCBBAA;
        bus.empty_i = 1'b0;
        bus.ready_i = 1'b1;
        wait_pop("bp");
        tick();
        bus.empty_i = 1'b1;
        chk("bp_aa", 32'(bus.byte_o), 32'hAA);
        tick();
        chk("bp_bb", 32'(bus.byte_o), 32'hBB);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.valid_o), 32'd1);
            chk("bp_hold_byte",  32'(bus.byte_o),  32'hBB);
        end
        bus.ready_i = 1'b1;
        tick();
        chk("bp_cc", 32'(bus.byte_o), 32'hCC);
        tick();
        chk("bp_dd", 32'(bus.byte_o), 32'hDD);
`ifdef SER_CHECKSUM_EN
        tick();
        chk("bp_csum", 32'(bus.byte_o), 32'h00);
`endif
        tick();
        chk("bp_guard_valid", 32'(bus.valid_o), 32'd0);
        chk("bp_words", 32'(bus.words_o), 32'd2);
        tick();
        tick();

        // Back-to-back: three words with empty held low until the third pop
        rst = 1'b0;
        tick();
        chk("b2b_rst_words", 32'(bus.words_o), 32'd0);
        rst = 1'b1;
        p0 = pop_cnt;
        last_cyc = 0;
        bus.data_i  = bw[0];
        bus.empty_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_pop("b2b");
            if (w > 0) begin
                sep = cyc - last_cyc;
                chk("b2b_sep", (sep >= int'(BYTES) + 3) ? 32'd1 : 32'd0, 32'd1);
            end
            last_cyc = cyc;
            tick();
            if (w < 2) bus.data_i = bw[w+1];
            else bus.empty_i = 1'b1;
            for (int b = 0; b < BYTES; b++) begin
                if (b > 0) tick();
                chk("b2b_byte", 32'(bus.byte_o), 32'(bw[w][8*b +: 8]));
            end
`ifdef SER_CHECKSUM_EN
            tick();
            chk("b2b_csum", 32'(bus.byte_o), 32'(xsum(bw[w])));
`endif
        end
        tick();
        tick();
        tick();
        chk("b2b_pops",   32'(pop_cnt - p0), 32'd3);
        chk("b2b_dbl",    32'(dbl_pop),      32'd0);
        chk("b2b_words",  32'(bus.words_o),  32'd3);

        // Reset in the middle of a word
        bus.data_i  = 32'hDDCCBBAA;
        bus.empty_i = 1'b0;
        wait_pop("mid");
        tick();
        bus.empty_i = 1'b1;
        chk("mid_aa", 32'(bus.byte_o), 32'hAA);
        tick();
        chk("mid_bb", 32'(bus.byte_o), 32'hBB);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_byte",  32'(bus.byte_o),  32'h00);
        chk("mid_busy",  32'(bus.busy_o),  32'd0);
        chk("mid_pop",   32'(bus.pop_o),   32'd0);
        chk("mid_words", 32'(bus.words_o), 32'd0);
        p0 = pop_cnt;
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_idle_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_no_repop",  32'(pop_cnt - p0), 32'd0);
        run_word("fresh", 32'h0D0C0B0A);
        chk("fresh_words", 32'(bus.words_o), 32'd1);

        // Word counter wrap
        force dut.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        chk("wrap_pre", 32'(bus.words_o), 32'h0000FFFF);
        run_word("wrap", 32'h5A6B7C8D);
        chk("wrap_words", 32'(bus.words_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
